forward_select_unit: RTL and testbench
======================================

// Module: forward_select_unit
// PURPOSE
//  Producer of the 2-bit select codes consumed by the pipeline's 3-to-1 operand muxes
//  (0 = register file, 1 = MEM/WB result, 2 = EX/MEM result).
//  Keeps its own shadow pipeline (EX, MEM, WB) of destination-register info for in-flight
//  instructions. Emits registered forward selects for the EX-stage operands.
//  Raises a load-use stall and inserts bubbles.
//  Sits between the ID/EX register and the ALU-input muxes.
// PARAMETERS
//  AW      5   register-address width
//  STAT_W  16  width of statistics counters (used only with FWD_STATS_EN)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   reset, asynchronous, active-high
//  id_valid_i     in   1   ID holds a real instruction
//  id_rs_i        in   AW  ID source A register
//  id_rt_i        in   AW  ID source B register
//  id_rd_i        in   AW  ID destination register
//  id_regwrite_i  in   1   ID instruction writes rd
//  id_memread_i   in   1   ID instruction is a load
//  flush_i        in   1   squash instruction entering EX (branch taken)
//  stall_o        out  1   comb.; hold PC and IF/ID, bubble into ID/EX
//  fwd_a_o        out  2   registered select for EX operand A mux
//  fwd_b_o        out  2   registered select for EX operand B mux
// BEHAVIOUR
//  - Stage record {valid, rd, regwrite, memread}; three regs: ex_q, mem_q, wb_q.
//  - Reset (async, rst_i=1): all records valid=0; fwd_a_o=fwd_b_o=0.
//    stall_o=0 follows from ex_q.valid=0.
//  - Every edge: wb_q<=mem_q; mem_q<=ex_q.
//  - ex_q<=ID record when id_valid_i & ~stall_o & ~flush_i; otherwise bubble (valid=0).
//  - "writer(s)" = s.valid & s.regwrite & s.rd!=0. Register 0 is never forwarded and never stalls.
//  - stall_o = id_valid_i & ex_q.valid & ex_q.memread & ex_q.rd!=0
//    & (ex_q.rd==id_rs_i | ex_q.rd==id_rt_i).
//  - Next fwd_a_o (one-cycle latency; valid while the instruction sits in EX):
//    - 2 if writer(ex_q) & ex_q.rd==id_rs_i.
//    - else 1 if writer(mem_q) & mem_q.rd==id_rs_i.
//    - else 0.
//    - fwd_b_o: same rule using id_rt_i.
//    - EX/MEM wins over MEM/WB when both match (youngest value).
//  - Code 3 is never produced.
//  - When ex_q is loaded with a bubble (stall, flush, !id_valid_i), fwd_a_o/fwd_b_o load 0.
//  - flush_i and stall_o together: flush wins; bubble inserted. stall_o is still reported (upstream holds).
//  - Load in MEM matching: select 1 is produced the cycle after the stall (data from MEM/WB).
//  - Reset mid-operation: all in-flight records are dropped immediately. No forward from pre-reset instructions.
// CONFIGURATION
//  `define FWD_STATS_EN:
//  - Adds out ports fwd_cnt_o[STAT_W-1:0] and stall_cnt_o[STAT_W-1:0].
//  - fwd_cnt_o counts edges where a nonzero select is loaded (A and B both nonzero count 2).
//  - stall_cnt_o counts cycles with stall_o=1.
//  - Both counters wrap at 2^STAT_W and reset to 0.
//  Without the macro: ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package fwd_pkg:
//  - SEL_RF=2'd0, SEL_WB=2'd1, SEL_MEM=2'd2.
//  - typedef stage_rec_t {valid, rd[AW-1:0], regwrite, memread}.
//  - function is_writer().
//  Sub-module fwd_compare: one per operand (x2). Inputs: src reg, ex_q, mem_q. Output: 2-bit select (priority encoder).
// TESTING
//  - Reset: rst_i=1 async mid-cycle -> fwd_a_o=fwd_b_o=0, stall_o=0 at once.
//    Records cleared; next cycle no forward despite matching rd.
//  - EX hazard: add $3 then sub rs=$3 -> fwd_a_o=2 next cycle.
//    Sub with rt=$3 instead -> fwd_b_o=2.
//  - MEM hazard: add $4, nop, or rs=$4 -> fwd_a_o=1.
//    add $4, add $4, or rs=$4 -> fwd_a_o=2 (priority).
//  - Load-use: lw $5 then and rs=$5 -> stall_o=1 for exactly 1 cycle.
//    Bubble enters EX (selects=0); after the bubble, and gets fwd_a_o=1.
//  - Zero reg/flush: add $0 then rs=$0 -> select 0.
//    flush_i with matching ID -> EX bubble, selects 0, later instructions see no forward from it.
//  - FWD_STATS_EN: above sequence -> stall_cnt_o=1; fwd_cnt_o = number of nonzero selects.
//    Preload near 2^STAT_W-1 via long loop -> wraps to 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: select codes, in-flight stage record and writer test shared by the forwarding unit.
package fwd_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_rec_t;

    // Register 0 is hardwired, so it is never a forwarding source.
    function automatic logic is_writer(input stage_rec_t s);
        return s.valid & s.regwrite & (s.rd != '0);
    endfunction
endpackage

// File: rtl/fwd_compare.sv
// fwd_compare: priority-encodes the operand select for one source register.
module fwd_compare
    import fwd_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  stage_rec_t        ex_i,
    input  stage_rec_t        mem_i,
    output logic [1:0]        sel_o
);
    // The younger EX/MEM result shadows an older MEM/WB write to the same register.
    always_comb
        sel_o = (is_writer(ex_i) && ex_i.rd == src_i)   ? SEL_MEM :
                (is_writer(mem_i) && mem_i.rd == src_i) ? SEL_WB  : SEL_RF;
endmodule

// File: rtl/forward_select_unit.sv
// forward_select_unit: registered EX-operand forward selects plus load-use stall.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module forward_select_unit
    import fwd_pkg::*;
#(
    parameter int AW = REG_AW
`ifdef FWD_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic [AW-1:0] id_rd_i,
    input  logic          id_regwrite_i,
    input  logic          id_memread_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic [1:0]    fwd_a_o,
    output logic [1:0]    fwd_b_o
`ifdef FWD_STATS_EN
    ,
    output logic [STAT_W-1:0] fwd_cnt_o,
    output logic [STAT_W-1:0] stall_cnt_o
`endif
);
    stage_rec_t ex_q, ex_d, mem_q;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;
    logic       load;

    fwd_compare u_cmp_a (.src_i(id_rs_i), .ex_i(ex_q), .mem_i(mem_q), .sel_o(sel_a));
    fwd_compare u_cmp_b (.src_i(id_rt_i), .ex_i(ex_q), .mem_i(mem_q), .sel_o(sel_b));

    always_comb begin
        stall_o = id_valid_i & ex_q.valid & ex_q.memread & (ex_q.rd != '0)
                & ((ex_q.rd == id_rs_i) | (ex_q.rd == id_rt_i));
        load    = id_valid_i & ~stall_o & ~flush_i;
        ex_d    = load ? '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i,
                           memread: id_memread_i} : '0;
        fwd_a_d = load ? sel_a : SEL_RF;
        fwd_b_d = load ? sel_b : SEL_RF;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;

`ifdef FWD_STATS_EN
    logic [STAT_W-1:0] fwd_cnt_q, fwd_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q + STAT_W'(fwd_a_d != SEL_RF) + STAT_W'(fwd_b_d != SEL_RF);
        stall_cnt_d = stall_cnt_q + STAT_W'(stall_o);
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end

    assign fwd_cnt_o   = fwd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_forward_select_unit.sv
// tb_forward_select_unit: directed instruction stream with a queued scoreboard for selects and stall.
module tb_forward_select_unit;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
    logic       id_regwrite_i = 1'b0, id_memread_i = 1'b0, flush_i = 1'b0;
    logic       stall_o;
    logic [1:0] fwd_a_o, fwd_b_o;
`ifdef FWD_STATS_EN
    logic [15:0] fwd_cnt_o, stall_cnt_o;
`endif

    typedef struct {
        logic       st;
        logic [1:0] a;
        logic [1:0] b;
        int         row;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   row_n = 0;

    forward_select_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
        .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
        .id_memread_i(id_memread_i), .flush_i(flush_i), .stall_o(stall_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
`ifdef FWD_STATS_EN
        , .fwd_cnt_o(fwd_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0d, want %0d", nm, row, act, exp);
        end
    endtask

    // Row: ID instruction for this cycle; est = stall for it, ea/eb = selects currently on the outputs.
    task automatic drive(input logic v, input int rs, input int rt, input int rd, input logic rw,
                         input logic mr, input logic fl, input logic est, input int ea, input int eb);
        @(negedge clk_i);
        id_valid_i = v; id_rs_i = 5'(rs); id_rt_i = 5'(rt); id_rd_i = 5'(rd);
        id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
        q.push_back('{st: est, a: 2'(ea), b: 2'(eb), row: row_n});
        row_n++;
    endtask

    task automatic nop(input int ea, input int eb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, ea, eb);
    endtask

    initial forever begin
        @(negedge clk_i);
        #2;
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", e.row, 16'(stall_o), 16'(e.st));
            chk("fwd_a", e.row, 16'(fwd_a_o), 16'(e.a));
            chk("fwd_b", e.row, 16'(fwd_b_o), 16'(e.b));
        end
    end

    initial begin
        id_valid_i = 1'b1; id_rs_i = 5'd3; id_rt_i = 5'd3;
        #12;
        chk("reset_stall", -1, 16'(stall_o), 16'd0);
        chk("reset_fwd_a", -1, 16'(fwd_a_o), 16'd0);
        chk("reset_fwd_b", -1, 16'(fwd_b_o), 16'd0);
        @(negedge clk_i);
        rst_i = 1'b0; id_valid_i = 1'b0;
        // EX hazard on A, then on B
        drive(1, 1, 2, 3, 1, 0, 0, 0, 0, 0);
        drive(1, 3, 1, 6, 1, 0, 0, 0, 0, 0);
        nop(2, 0);
        drive(1, 1, 2, 3, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 3, 7, 1, 0, 0, 0, 0, 0);
        nop(0, 2);
        // MEM hazard, then EX/MEM priority over MEM/WB
        drive(1, 1, 2, 4, 1, 0, 0, 0, 0, 0);
        nop(0, 0);
        drive(1, 4, 2, 8, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 2, 4, 1, 0, 0, 0, 1, 0);
        drive(1, 1, 2, 4, 1, 0, 0, 0, 0, 0);
        drive(1, 4, 4, 9, 1, 0, 0, 0, 0, 0);
        nop(2, 2);
        // load-use: one stall cycle, bubble, then MEM/WB select
        drive(1, 1, 2, 5, 1, 1, 0, 0, 0, 0);
        drive(1, 5, 2, 10, 1, 0, 0, 1, 0, 0);
        drive(1, 5, 2, 10, 1, 0, 0, 0, 0, 0);
        nop(1, 0);
        // register 0 never forwards
        drive(1, 1, 2, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 11, 1, 0, 0, 0, 0, 0);
        nop(0, 0);
        // flush of a matching instruction, and its rd is never forwarded later
        drive(1, 1, 2, 12, 1, 0, 0, 0, 0, 0);
        drive(1, 12, 12, 13, 1, 0, 1, 0, 0, 0);
        drive(1, 13, 1, 14, 1, 0, 0, 0, 0, 0);
        nop(0, 0);
        // flush together with load-use: stall still reported, bubble inserted
        drive(1, 1, 2, 5, 1, 1, 0, 0, 0, 0);
        drive(1, 5, 2, 10, 1, 0, 1, 1, 0, 0);
        drive(1, 5, 2, 10, 1, 0, 0, 0, 0, 0);
        nop(1, 0);
        nop(0, 0);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk_i);
        if (q.size() != 0) chk("drain", -1, 16'(q.size()), 16'd0);
        #3;
`ifdef FWD_STATS_EN
        chk("stall_cnt", -1, stall_cnt_o, 16'd2);
        chk("fwd_cnt", -1, fwd_cnt_o, 16'd7);
`endif
        // async reset mid-cycle with live forwards and a pending stall
        @(negedge clk_i);
        id_valid_i = 1; id_rs_i = 1; id_rt_i = 2; id_rd_i = 3; id_regwrite_i = 1; id_memread_i = 0;
        @(negedge clk_i);
        id_rs_i = 3; id_rt_i = 3; id_rd_i = 7; id_memread_i = 1;
        @(negedge clk_i);
        id_rs_i = 7; id_rt_i = 2; id_rd_i = 10; id_memread_i = 0;
        #1;
        chk("pre_rst_stall", -2, 16'(stall_o), 16'd1);
        chk("pre_rst_fwd_a", -2, 16'(fwd_a_o), 16'd2);
        chk("pre_rst_fwd_b", -2, 16'(fwd_b_o), 16'd2);
        rst_i = 1'b1;
        #1;
        chk("rst_stall", -2, 16'(stall_o), 16'd0);
        chk("rst_fwd_a", -2, 16'(fwd_a_o), 16'd0);
        chk("rst_fwd_b", -2, 16'(fwd_b_o), 16'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        id_rs_i = 3; id_rt_i = 7; id_rd_i = 9;
        #1;
        chk("post_rst_stall", -2, 16'(stall_o), 16'd0);
        @(posedge clk_i);
        #1;
        chk("post_rst_fwd_a", -2, 16'(fwd_a_o), 16'd0);
        chk("post_rst_fwd_b", -2, 16'(fwd_b_o), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
